avalon_mm_master_port: RTL and testbench
========================================

// Module: avalon_mm_master_port
// PURPOSE
//  Avalon-MM initiator between the MIPS core's load/store path and the data/instruction bus.
//  Turns one CPU request (byte/half/word, signed/unsigned) into one aligned 32-bit Avalon read or write.
//  Holds the command stable until waitrequest drops, then returns lane-extracted read data or a done pulse.
//  Sits opposite the testbench RAM slave; one outstanding transfer, no bursts, no pipelining.
// PARAMETERS
//  ADDR_W          32    byte-address width of cpu_addr / avm_address
//  TIMEOUT_CYCLES  1024  wait-state limit before abort (used only with AVM_TIMEOUT_EN)
// PORTS
//  clk              in   1       single clock, all logic on rising edge
//  reset_n          in   1       asynchronous, active-low reset
//  cpu_req          in   1       request valid; accepted when cpu_req & cpu_ready at a rising edge
//  cpu_ready        out  1       high in IDLE only
//  cpu_write        in   1       1 = store, 0 = load
//  cpu_size         in   2       00 byte, 01 half, 10 word, 11 illegal
//  cpu_signed       in   1       load sign-extends when 1, zero-extends when 0
//  cpu_addr         in   ADDR_W  byte address
//  cpu_wdata        in   32      store data, right-justified
//  cpu_done         out  1       one-cycle completion pulse
//  cpu_rdata        out  32      extended load data; valid while cpu_done, held until next load done
//  cpu_err          out  1       one-cycle pulse with cpu_done; misaligned/illegal request or timeout
//  avm_address      out  ADDR_W  word-aligned: {cpu_addr[ADDR_W-1:2],2'b00}
//  avm_read         out  1       read command
//  avm_write        out  1       write command
//  avm_waitrequest  in   1       slave stall; transfer completes at first edge with command high and this low
//  avm_writedata    out  32      store data replicated onto enabled lanes
//  avm_byteenable   out  4       lane enables
//  avm_readdata     in   32      sampled at the completing edge
// BEHAVIOUR
//  Reset: all outputs 0 except cpu_ready=1; state IDLE. Async assert drops avm_read/avm_write at once.
//   Reset mid-transfer abandons the transfer; no done pulse is produced.
//  FSM: IDLE -> ACCESS on accepted legal request; ACCESS -> IDLE at the completing edge.
//   IDLE -> IDLE with cpu_done=cpu_err=1 next cycle on an illegal request; no bus command is issued.
//  Illegal request: size 11, half with addr[0]=1, or word with addr[1:0]!=00.
//  Command registers (address, writedata, byteenable, read/write) load at acceptance.
//   They are constant throughout ACCESS; read and write are never both high.
//  Byteenable: byte=4'b0001<<a[1:0]; half=a[1]?4'b1100:4'b0011; word=4'b1111.
//  Writedata: byte={4{wdata[7:0]}}, half={2{wdata[15:0]}}, word=wdata.
//  Load: select lane by addr[1:0]/size, extend to 32 bits per cpu_signed; register into cpu_rdata.
//  Latency: accept at edge N; command high from N+1; completes at first edge M>N with waitrequest=0.
//   cpu_done in cycle after M; zero wait states gives request-to-done = 2 cycles.
//  cpu_ready is high in the done cycle, so back-to-back requests are accepted there.
//  cpu_req while not ready is ignored (not queued); CPU must hold it.
//  Stores leave cpu_rdata unchanged.
// CONFIGURATION
//  AVM_TIMEOUT_EN defined:
//   - Counter clears at acceptance and increments each ACCESS cycle with waitrequest=1.
//   - On reaching TIMEOUT_CYCLES: drop command, return IDLE, pulse cpu_done+cpu_err; rdata unchanged.
//  Undefined: no counter; ACCESS waits indefinitely; cpu_err only for illegal requests.
// TESTING
//  1 Word store addr 0x10 data 0xDEADBEEF, waitrequest=0 -> avm_write 1 cycle, be=1111, done 2 cycles after accept; RAM bytes 0x10..0x13 = EF BE AD DE.
//  2 Signed byte load addr 0x13 over word 0x80FF7F01 -> be=1000, cpu_rdata=0xFFFFFF80; unsigned -> 0x00000080.
//  3 Half store addr 0x22 data 0x0000ABCD -> be=1100, writedata=0xABCDABCD; unsigned half load 0x22 -> 0x0000ABCD.
//  4 waitrequest held high 5 cycles -> address/be/read stable all 5, done exactly once, 7 cycles after accept.
//  5 Word load addr 0x06 or size 11 -> no avm_read/avm_write, done+err pulse next cycle, ready stays 1.
//  6 reset_n low mid-ACCESS -> read/write 0 immediately, no done; with AVM_TIMEOUT_EN, TIMEOUT_CYCLES=8, waitrequest stuck 1 -> err+done after 8 stall cycles.

Source files
------------

// File: rtl/avalon_mm_master_port.sv
// avalon_mm_master_port: Avalon-MM initiator for the CPU load/store path.
// One CPU request (byte/half/word, signed/unsigned) becomes one aligned 32-bit
// Avalon read or write; read data is lane-extracted and extended.
// Optional feature macro: AVM_TIMEOUT_EN (wait-state timeout abort).
//
// Handshakes:
//   CPU side  - a request is taken when cpu_req & cpu_ready at a rising edge;
//               cpu_ready is high only in IDLE, and requests seen while busy
//               are dropped, not queued.
//   Bus side  - avm_read/avm_write and the address, byteenable and writedata
//               registers stay constant until a rising edge where the command
//               is high and avm_waitrequest is low. That edge completes the
//               transfer.
module avalon_mm_master_port #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  output logic              cpu_ready,
  input  logic              cpu_write,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_signed,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  input  logic              avm_waitrequest,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  // A zero timeout would make the abort counter meaningless.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
  end

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:2] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

`ifdef AVM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic        req_illegal;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] lane;
  logic [31:0] load_ext;

  // Classify the incoming request and build its lane enables / replicated data.
  always_comb begin
    req_illegal = (cpu_size == 2'b11) ||
                  (cpu_size == 2'b01 && cpu_addr[0]) ||
                  (cpu_size == 2'b10 && cpu_addr[1:0] != 2'b00);
    req_be    = 4'b0000;
    req_wdata = cpu_wdata;
    case (cpu_size)
      2'b00: begin
        req_be    = 4'b0001 << cpu_addr[1:0];
        req_wdata = {4{cpu_wdata[7:0]}};
      end
      2'b01: begin
        req_be    = cpu_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{cpu_wdata[15:0]}};
      end
      2'b10: begin
        req_be    = 4'b1111;
        req_wdata = cpu_wdata;
      end
      default: begin
        req_be    = 4'b0000;
        req_wdata = cpu_wdata;
      end
    endcase
  end

  // Pick the addressed lane out of the read word and extend it to 32 bits.
  always_comb begin
    lane = avm_readdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_ext = {{24{sgn_q & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{16{sgn_q & lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // Next-state logic: accept in IDLE, wait out waitrequest in ACCESS.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    off_d   = off_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef AVM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (req_illegal) begin
            // Rejected without touching the bus.
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            addr_d  = cpu_addr[ADDR_W-1:2];
            wdata_d = req_wdata;
            be_d    = req_be;
            rd_d    = ~cpu_write;
            wr_d    = cpu_write;
            off_d   = cpu_addr[1:0];
            size_d  = cpu_size;
            sgn_d   = cpu_signed;
`ifdef AVM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ST_ACCESS: begin
        if (!avm_waitrequest) begin
          state_d = ST_IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          if (rd_q) rdata_d = load_ext;
        end
`ifdef AVM_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          // Last permitted stall cycle: abandon the command, keep old rdata.
          state_d = ST_IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and command registers; async reset drops any bus command at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef AVM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef AVM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign cpu_ready      = (state_q == ST_IDLE);
  assign cpu_done       = done_q;
  assign cpu_err        = err_q;
  assign cpu_rdata      = rdata_q;
  assign avm_address    = {addr_q, 2'b00};
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;

endmodule

// File: tb/tb_avalon_mm_master_port.sv
// tb_avalon_mm_master_port: directed + random transactions against a byte-array
// reference model; the bench also plays the Avalon RAM slave.
module tb_avalon_mm_master_port;

  logic        clk;
  logic        reset_n;
  logic        cpu_req;
  logic        cpu_ready;
  logic        cpu_write;
  logic [1:0]  cpu_size;
  logic        cpu_signed;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic        avm_waitrequest;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;

  avalon_mm_master_port #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_write(cpu_write),
    .cpu_size(cpu_size), .cpu_signed(cpu_signed), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cpu_err(cpu_err), .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_waitrequest(avm_waitrequest),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  model_mem[256];
  logic [7:0]  slave_mem[256];
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_illegal(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit sg, input logic [31:0] a);
    int    n;
    longint v;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(model_mem[(a + i) % 256]) << (8 * i);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    int b;
    b = int'(a & 32'hFC);
    return {slave_mem[b + 3], slave_mem[b + 2], slave_mem[b + 1], slave_mem[b]};
  endfunction

  // ---------------- driver ----------------
  // Starts in an idle cycle (#1 after an edge) and returns in the done cycle,
  // so consecutive calls exercise back-to-back acceptance.
  task automatic do_txn(input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int waits, output logic [31:0] rd);
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int          n;
    check("ready_before_req", cpu_ready, 1);
    cpu_req = 1'b1; cpu_write = wr; cpu_size = sz; cpu_signed = sg;
    cpu_addr = a; cpu_wdata = wd;
    @(posedge clk); #1;
    // Scramble the CPU inputs: the command must come from registers.
    cpu_req = 1'b0; cpu_write = 1'($urandom); cpu_size = 2'($urandom);
    cpu_addr = $urandom; cpu_wdata = $urandom; cpu_signed = 1'($urandom);
    if (is_illegal(sz, a)) begin
      check("illegal_done", cpu_done, 1);
      check("illegal_err", cpu_err, 1);
      check("illegal_ready", cpu_ready, 1);
      check("illegal_no_cmd", {avm_read, avm_write}, 0);
      check("illegal_rdata_kept", cpu_rdata, last_rdata);
      rd = cpu_rdata;
      return;
    end
    n = 1 << sz;
    exp_be = 4'b0000;
    for (int i = 0; i < n; i++) exp_be[(a % 4) + i] = 1'b1;
    for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wd[8*(j % n) +: 8];
    if (wr) begin
      for (int i = 0; i < n; i++) model_mem[(a + i) % 256] = wd[8*i +: 8];
    end else begin
      exp_q.push_back(model_load(sz, sg, a));
    end
    for (int k = 0; k <= waits; k++) begin
      avm_waitrequest = (k < waits);
      avm_readdata    = (k < waits) ? $urandom : slave_word(a);
      check("cmd_addr", avm_address, a & ~32'h3);
      check("cmd_be", avm_byteenable, exp_be);
      check("cmd_rw", {avm_read, avm_write}, {~wr, wr});
      if (wr) check("cmd_wdata", avm_writedata, exp_wd);
      check("no_early_done", cpu_done, 0);
      check("busy_not_ready", cpu_ready, 0);
      if (k == waits && wr) begin
        for (int j = 0; j < 4; j++)
          if (avm_byteenable[j]) slave_mem[int'(avm_address & 32'hFC) + j] = avm_writedata[8*j +: 8];
      end
      @(posedge clk); #1;
    end
    avm_waitrequest = 1'b0;
    check("done_pulse", cpu_done, 1);
    check("done_no_err", cpu_err, 0);
    check("cmd_dropped", {avm_read, avm_write}, 0);
    check("ready_in_done", cpu_ready, 1);
    if (!wr) begin
      last_rdata = exp_q.pop_front();
      check("load_rdata", cpu_rdata, last_rdata);
    end else begin
      check("store_rdata_kept", cpu_rdata, last_rdata);
    end
    rd = cpu_rdata;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] a;
    int          w;

    reset_n = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0; cpu_size = 2'b00;
    cpu_signed = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    avm_waitrequest = 1'b0; avm_readdata = '0;
    last_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'($urandom);
      slave_mem[i] = model_mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", cpu_ready, 1);
    check("rst_done_err", {cpu_done, cpu_err}, 0);
    check("rst_cmd", {avm_read, avm_write}, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_addr_be", {avm_address[3:0], avm_byteenable}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: word store
    do_txn(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, rd);
    check("t1_ram", {slave_mem[16], slave_mem[17], slave_mem[18], slave_mem[19]}, 32'hEFBEADDE);
    // 2: byte loads over 0x80FF7F01
    do_txn(1, 2'd2, 0, 32'h10, 32'h80FF7F01, 0, rd);
    do_txn(0, 2'd0, 1, 32'h13, 32'h0, 0, rd);
    check("t2_signed_byte", rd, 32'hFFFFFF80);
    do_txn(0, 2'd0, 0, 32'h13, 32'h0, 1, rd);
    check("t2_unsigned_byte", rd, 32'h00000080);
    // 3: half store/load at 0x22
    do_txn(1, 2'd1, 0, 32'h22, 32'h0000ABCD, 0, rd);
    do_txn(0, 2'd1, 0, 32'h22, 32'h0, 0, rd);
    check("t3_half", rd, 32'h0000ABCD);
    do_txn(0, 2'd1, 1, 32'h22, 32'h0, 2, rd);
    check("t3_half_signed", rd, 32'hFFFFABCD);
    // 4: five wait states
    do_txn(0, 2'd2, 0, 32'h10, 32'h0, 5, rd);
    check("t4_word", rd, 32'h80FF7F01);
    // 5: illegal requests
    do_txn(0, 2'd2, 0, 32'h06, 32'h0, 0, rd);
    do_txn(1, 2'd3, 0, 32'h08, 32'h1234, 0, rd);
    do_txn(1, 2'd1, 0, 32'h21, 32'h1234, 0, rd);

    // 6: reset in the middle of a stalled read
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h40;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    avm_waitrequest = 1'b1;
    @(posedge clk); #1;
    check("t6_read_active", avm_read, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_read_dropped", {avm_read, avm_write}, 0);
    check("t6_ready_after_rst", cpu_ready, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    avm_waitrequest = 1'b0;
    last_rdata = '0;
    for (int k = 0; k < 3; k++) begin
      check("t6_no_done", {cpu_done, cpu_err}, 0);
      @(posedge clk); #1;
    end
    check("t6_rdata_cleared", cpu_rdata, 0);

`ifdef AVM_TIMEOUT_EN
    // Timeout: waitrequest stuck high, abort after 8 stall cycles.
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h44;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    avm_waitrequest = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("to_stalling", {avm_read, cpu_done}, 2'b10);
      @(posedge clk); #1;
    end
    check("to_done_err", {cpu_done, cpu_err}, 2'b11);
    check("to_cmd_dropped", avm_read, 0);
    check("to_rdata_kept", cpu_rdata, last_rdata);
    avm_waitrequest = 1'b0;
    @(posedge clk); #1;
    check("to_single_pulse", cpu_done, 0);
`endif

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & ~32'h1;
        if (sz == 2'd2) a = a & ~32'h3;
      end
      w = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 2);
      do_txn(wr, sz, 1'($urandom_range(0, 1)), a, $urandom, w, rd);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check("idle_no_done", cpu_done, 0);
      end
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
